ucsbece154b_icache: RTL and testbench

//  Set-associative, read-only instruction cache feeding the fetch stage of the pipelined RISC-V core.

---
 rtl/ucsbece154b_icache_if.sv | 24 ++
 rtl/ucsbece154b_icache.sv | 158 +++++++++++++++
 tb/tb_ucsbece154b_icache.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache's view; the master modport is the core/memory view.
interface ucsbece154b_icache_if #(
  parameter int ADR_WIDTH = 32
) ();
  logic                 ReadEnable_i;
  logic [ADR_WIDTH-1:0] ReadAddress_i;
  logic [31:0]          Instruction_o;
  logic                 Ready_o;
  logic                 MemReadRequest_o;
  logic [ADR_WIDTH-1:0] MemReadAddress_o;
  logic [31:0]          MemDataIn_i;
  logic                 MemDataReady_i;

  modport slave (
    input  ReadEnable_i, ReadAddress_i, MemDataIn_i, MemDataReady_i,
    output Instruction_o, Ready_o, MemReadRequest_o, MemReadAddress_o
  );

  modport master (
    output ReadEnable_i, ReadAddress_i, MemDataIn_i, MemDataReady_i,
    input  Instruction_o, Ready_o, MemReadRequest_o, MemReadAddress_o
  );
endinterface

// File: rtl/ucsbece154b_icache.sv
// Set-associative read-only instruction cache: combinational hits, block refill
// by word-per-beat burst into a line buffer, round-robin replacement per set.
module ucsbece154b_icache #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ADR_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  ucsbece154b_icache_if.slave  bus
);
  localparam int OFS_W   = $clog2(BLOCK_WORDS);
  localparam int SET_W   = $clog2(NUM_SETS);
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int OFS_LSB = 2 + OFS_W;
  localparam int SET_LSB = OFS_LSB;
  localparam int TAG_W   = ADR_WIDTH - OFS_LSB - SET_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  // storage
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]       vptr_q;
  logic [TAG_W-1:0]                     tag_q  [NUM_SETS][NUM_WAYS];
  logic [BLOCK_WORDS-1:0][31:0]         data_q [NUM_SETS][NUM_WAYS];

  // control
  state_t                       state_q, state_d;
  logic [OFS_W-1:0]             cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0]         adr_q, adr_d;
  logic [WAY_W-1:0]             victim_q, victim_d;
  logic                         useptr_q, useptr_d;
  logic [BLOCK_WORDS-1:0][31:0] line_q, line_d;
  logic                         fill_done;

  // lookup
  logic [OFS_W-1:0] rd_word;
  logic [SET_W-1:0] rd_set;
  logic [TAG_W-1:0] rd_tag;
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way;
  logic [1:0]       unused_byte;

  logic [SET_W-1:0] f_set;
  logic [TAG_W-1:0] f_tag;
  logic [WAY_W-1:0] vptr_nxt;

  logic        ready;
  logic [31:0] instr;
  logic        req;

  assign rd_word     = bus.ReadAddress_i[2 +: OFS_W];
  assign rd_set      = bus.ReadAddress_i[SET_LSB +: SET_W];
  assign rd_tag      = bus.ReadAddress_i[ADR_WIDTH-1 -: TAG_W];
  assign unused_byte = bus.ReadAddress_i[1:0];

  assign f_set    = adr_q[SET_LSB +: SET_W];
  assign f_tag    = adr_q[ADR_WIDTH-1 -: TAG_W];
  assign vptr_nxt = (NUM_WAYS == 1) ? '0 : victim_q + WAY_W'(1);

  // Descending scan so the lowest-index match/invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_set][w] && (tag_q[rd_set][w] == rd_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[rd_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    victim_d  = victim_q;
    useptr_d  = useptr_q;
    line_d    = line_q;
    fill_done = 1'b0;
    ready     = 1'b0;
    instr     = 32'h0;
    req       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ReadEnable_i && hit) begin
          ready = 1'b1;
          instr = data_q[rd_set][hit_way][rd_word];
        end else if (bus.ReadEnable_i) begin
          adr_d    = {bus.ReadAddress_i[ADR_WIDTH-1:OFS_LSB], {OFS_LSB{1'b0}}};
          victim_d = inv_found ? inv_way : vptr_q[rd_set];
          useptr_d = !inv_found;
          state_d  = REQ;
        end
      end
      REQ: begin
        req     = 1'b1;
        state_d = FILL;
      end
      FILL: begin
        if (bus.MemDataReady_i) begin
          line_d[cnt_q] = bus.MemDataIn_i;
          cnt_d         = cnt_q + OFS_W'(1);
          if (cnt_q == OFS_W'(BLOCK_WORDS - 1)) begin
            fill_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      victim_q <= '0;
      useptr_q <= 1'b0;
      line_q   <= '0;
      valid_q  <= '0;
      vptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      victim_q <= victim_d;
      useptr_q <= useptr_d;
      line_q   <= line_d;
      if (fill_done) begin
        valid_q[f_set][victim_q] <= 1'b1;
        if (useptr_q) vptr_q[f_set] <= vptr_nxt;
      end
    end
  end

  // Tag/data arrays carry no reset; the final beat goes straight from line_d.
  always_ff @(posedge clk) begin
    if (fill_done && !reset) begin
      tag_q[f_set][victim_q]  <= f_tag;
      data_q[f_set][victim_q] <= line_d;
    end
  end

  assign bus.Ready_o          = ready && !reset;
  assign bus.Instruction_o    = reset ? 32'h0 : instr;
  assign bus.MemReadRequest_o = req;
  assign bus.MemReadAddress_o = adr_q;
endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Directed bench for ucsbece154b_icache: cold miss, spatial hits, conflict and
// round-robin replacement, stalled beats and reset during a fill.
module tb_ucsbece154b_icache;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  ucsbece154b_icache_if #(.ADR_WIDTH(32)) bus ();

  ucsbece154b_icache dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.ReadAddress_i  = a;
    bus.ReadEnable_i   = 1'b1;
    bus.MemDataReady_i = 1'b0;
    #1;
    chk("hit_rdy", {31'b0, bus.Ready_o}, 32'd1);
    chk("hit_ins", bus.Instruction_o, exp);
    chk("hit_req", {31'b0, bus.MemReadRequest_o}, 32'd0);
  endtask

  // Miss on a, serve the burst with the given ready pattern (bit i = cycle i),
  // then check the retried hit returns word a[3:2] of the block.
  task automatic fill(input logic [31:0] a, input logic [31:0] base,
                      input logic [15:0] pat, input int plen);
    logic [31:0] blk;
    logic [31:0] beat;
    blk  = a & ~32'hF;
    beat = 0;
    @(negedge clk);
    bus.ReadAddress_i  = a;
    bus.ReadEnable_i   = 1'b1;
    bus.MemDataReady_i = 1'b0;
    #1;
    chk("miss_rdy", {31'b0, bus.Ready_o}, 32'd0);
    chk("miss_ins", bus.Instruction_o, 32'd0);
    chk("miss_req", {31'b0, bus.MemReadRequest_o}, 32'd0);
    @(negedge clk);
    bus.ReadAddress_i  = 32'h0000_0F00;
    bus.MemDataReady_i = 1'b1;
    bus.MemDataIn_i    = 32'hBAD0_0000;
    #1;
    chk("req_pulse", {31'b0, bus.MemReadRequest_o}, 32'd1);
    chk("req_adr", bus.MemReadAddress_o, blk);
    chk("req_rdy", {31'b0, bus.Ready_o}, 32'd0);
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      bus.MemDataReady_i = pat[i];
      bus.MemDataIn_i    = pat[i] ? base + beat : 32'hDEAD_BEEF;
      if (pat[i]) beat++;
      #1;
      chk("fill_rdy", {31'b0, bus.Ready_o}, 32'd0);
      chk("fill_req", {31'b0, bus.MemReadRequest_o}, 32'd0);
    end
    @(negedge clk);
    bus.MemDataReady_i = 1'b0;
    bus.ReadAddress_i  = a;
    #1;
    chk("rtn_rdy", {31'b0, bus.Ready_o}, 32'd1);
    chk("rtn_ins", bus.Instruction_o, base + {28'b0, a[3:2]});
    chk("rtn_adr_hold", bus.MemReadAddress_o, blk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset              = 1'b1;
    bus.ReadEnable_i   = 1'b0;
    bus.ReadAddress_i  = 32'h0;
    bus.MemDataIn_i    = 32'h0;
    bus.MemDataReady_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy", {31'b0, bus.Ready_o}, 32'd0);
    chk("rst_req", {31'b0, bus.MemReadRequest_o}, 32'd0);
    chk("rst_adr", bus.MemReadAddress_o, 32'd0);
    chk("rst_ins", bus.Instruction_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_rdy", {31'b0, bus.Ready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_noreq", {31'b0, bus.MemReadRequest_o}, 32'd0);

    // T1 cold miss, back-to-back beats: Ready at t+6
    fill(32'h100, 32'hA0, 16'h000F, 4);
    // T2 spatial hits
    hit(32'h104, 32'hA1);
    hit(32'h108, 32'hA2);
    hit(32'h10C, 32'hA3);
    @(negedge clk);
    bus.ReadEnable_i  = 1'b0;
    bus.ReadAddress_i = 32'h104;
    #1;
    chk("noen_rdy", {31'b0, bus.Ready_o}, 32'd0);
    chk("noen_ins", bus.Instruction_o, 32'd0);
    hit(32'h100, 32'hA0);

    // T3 fill remaining ways of set 0, then conflict
    fill(32'h180, 32'h20, 16'h000F, 4);
    fill(32'h200, 32'h30, 16'h000F, 4);
    fill(32'h280, 32'h40, 16'h000F, 4);
    hit(32'h100, 32'hA0);
    hit(32'h184, 32'h21);
    hit(32'h208, 32'h32);
    hit(32'h28C, 32'h43);
    fill(32'h300, 32'h50, 16'h000F, 4);   // evicts way 0 (0x100)
    hit(32'h180, 32'h20);
    hit(32'h304, 32'h51);
    // T4 round robin: ways 1,2 evicted, pointer then 3
    fill(32'h380, 32'h60, 16'h000F, 4);
    fill(32'h400, 32'h70, 16'h000F, 4);
    hit(32'h280, 32'h40);
    hit(32'h300, 32'h50);
    hit(32'h380, 32'h60);
    hit(32'h400, 32'h70);
    fill(32'h100, 32'hB0, 16'h000F, 4);   // 0x100 misses, lands in way 3
    fill(32'h280, 32'hC0, 16'h000F, 4);   // way 3 gone -> 0x280 misses, evicts way 0
    hit(32'h104, 32'hB1);
    hit(32'h388, 32'h62);
    hit(32'h40C, 32'h73);
    hit(32'h28C, 32'hC3);
    fill(32'h300, 32'hD0, 16'h000F, 4);

    // T5 stalled beats 1,0,0,1,1,0,1 into set 4
    fill(32'h044, 32'hE0, 16'h0059, 7);
    hit(32'h040, 32'hE0);
    hit(32'h048, 32'hE2);
    hit(32'h04C, 32'hE3);

    // T6 reset after two beats of a 0x100 fill
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset             = 1'b0;
    bus.ReadAddress_i = 32'h100;
    bus.ReadEnable_i  = 1'b1;
    #1;
    chk("t6_miss", {31'b0, bus.Ready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("t6_req", {31'b0, bus.MemReadRequest_o}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.MemDataReady_i = 1'b1;
      bus.MemDataIn_i    = 32'hF0 + i;
    end
    @(negedge clk);
    reset           = 1'b1;
    bus.MemDataIn_i = 32'hF2;
    #1;
    chk("t6_rst_rdy", {31'b0, bus.Ready_o}, 32'd0);
    @(negedge clk);
    reset            = 1'b0;
    bus.ReadEnable_i = 1'b0;
    bus.MemDataIn_i  = 32'hF3;
    #1;
    chk("t6_idle_req", {31'b0, bus.MemReadRequest_o}, 32'd0);
    chk("t6_idle_rdy", {31'b0, bus.Ready_o}, 32'd0);
    @(negedge clk);
    bus.MemDataReady_i = 1'b0;
    #1;
    chk("t6_noreq", {31'b0, bus.MemReadRequest_o}, 32'd0);
    fill(32'h100, 32'h90, 16'h000F, 4);   // valid bits cleared: 0x100 misses
    fill(32'h048, 32'h80, 16'h000F, 4);   // set 4 also cleared
    hit(32'h10C, 32'h93);
    hit(32'h044, 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
